eh2_dec_gpr_wbq: RTL

EH2_DEC_GPR_WBQ -- requirements
Module: eh2_dec_gpr_wbq

---
 rtl/eh2_dec_gpr_wbq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/eh2_dec_gpr_wbq.sv
// rtl/eh2_dec_gpr_wbq.sv - in-order writeback queue sharing one GPR write port between load and divider
// Optional same-cycle bypass when empty: define RV_WBQ_BYPASS_EN.
module eh2_dec_gpr_wbq #(
   parameter int WBQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        nb_valid,
   input  logic        nb_tid,
   input  logic [4:0]  nb_addr,
   input  logic [31:0] nb_data,
   output logic        nb_ready,
   input  logic        div_valid,
   input  logic        div_tid,
   input  logic [4:0]  div_addr,
   input  logic [31:0] div_data,
   output logic        div_ready,
   input  logic        port_free,
   output logic        wb_wen,
   output logic        wb_wtid,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wd,
   input  logic        qry_tid,
   input  logic [4:0]  qry_addr,
   output logic        qry_hit,
   input  logic        scan_mode
);
   localparam int PW = $clog2(WBQ_DEPTH);
   localparam int CW = PW + 1;

   logic [CW-1:0] count;
   logic [PW-1:0] rptr, wptr, div_slot;
   logic          tid_q  [WBQ_DEPTH];
   logic [4:0]    addr_q [WBQ_DEPTH];
   logic [31:0]   data_q [WBQ_DEPTH];

   logic nb_nz, div_nz, nb_take, div_take, empty;
   logic byp_nb, byp_div, nb_enq, div_enq, deq;
   logic unused_scan;

   assign unused_scan = scan_mode;

   assign nb_nz     = nb_addr != 5'd0;
   assign div_nz    = div_addr != 5'd0;
   assign empty     = count == '0;
   assign nb_ready  = count < CW'(WBQ_DEPTH);
   // A pending nonzero load reserves a slot, so it wins the last free entry.
   assign div_ready = ({1'b0, count} + (CW+1)'(nb_valid & nb_nz)) < (CW+1)'(WBQ_DEPTH);

   assign nb_take  = nb_valid & nb_ready & nb_nz;
   assign div_take = div_valid & div_ready & div_nz;

`ifdef RV_WBQ_BYPASS_EN
   assign byp_nb  = rst_l & empty & port_free & nb_take;
   assign byp_div = rst_l & empty & port_free & div_take & ~nb_take;
`else
   assign byp_nb  = 1'b0;
   assign byp_div = 1'b0;
`endif

   assign nb_enq   = nb_take & ~byp_nb;
   assign div_enq  = div_take & ~byp_div;
   // Gated by rst_l so nothing queued reaches the port during a reset cycle.
   assign deq      = rst_l & ~empty & port_free;
   assign div_slot = wptr + PW'(nb_enq);

   always_comb begin
      wb_wen   = 1'b0;
      wb_wtid  = 1'b0;
      wb_waddr = 5'd0;
      wb_wd    = 32'd0;
      if (deq) begin
         wb_wen   = 1'b1;
         wb_wtid  = tid_q[rptr];
         wb_waddr = addr_q[rptr];
         wb_wd    = data_q[rptr];
      end else if (byp_nb) begin
         wb_wen   = 1'b1;
         wb_wtid  = nb_tid;
         wb_waddr = nb_addr;
         wb_wd    = nb_data;
      end else if (byp_div) begin
         wb_wen   = 1'b1;
         wb_wtid  = div_tid;
         wb_waddr = div_addr;
         wb_wd    = div_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else begin
         if (nb_enq) begin
            tid_q[wptr]  <= nb_tid;
            addr_q[wptr] <= nb_addr;
            data_q[wptr] <= nb_data;
         end
         if (div_enq) begin
            tid_q[div_slot]  <= div_tid;
            addr_q[div_slot] <= div_addr;
            data_q[div_slot] <= div_data;
         end
         wptr  <= wptr + PW'(nb_enq) + PW'(div_enq);
         rptr  <= rptr + PW'(deq);
         count <= count + CW'(nb_enq) + CW'(div_enq) - CW'(deq);
      end
   end

   // An entry is live when its distance from the head is below count.
   always_comb begin
      logic [PW-1:0] offset;
      qry_hit = 1'b0;
      offset  = '0;
      for (int i = 0; i < WBQ_DEPTH; i++) begin
         offset = PW'(i) - rptr;
         if (({1'b0, offset} < count) && (tid_q[i] == qry_tid) &&
             (addr_q[i] == qry_addr) && (qry_addr != 5'd0))
            qry_hit = 1'b1;
      end
   end
endmodule
